// File: rtl/voting_machine.sv
// -----------------------------------------------------------------------------
// voting_machine
//   Three-candidate vote counter. Each press of a debounced front-panel button
//   adds one vote to that candidate's tally. Tallies stay hidden (outputs held
//   at 0) until the poll is closed. Closing the poll publishes the tallies and
//   freezes them until the next reset.
//
// Ports
//   clk             : system clock, rising-edge active
//   rst             : synchronous active-low reset
//   i_candidate_1   : vote button, candidate 1 (1 = pressed)
//   i_candidate_2   : vote button, candidate 2 (1 = pressed)
//   i_candidate_3   : vote button, candidate 3 (1 = pressed)
//   i_voting_over   : close-the-poll request (1 = close)
//   o_count1..3     : published tallies, zero until the poll is closed
// -----------------------------------------------------------------------------
module voting_machine #(
  parameter int COUNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_candidate_1,
  input  logic               i_candidate_2,
  input  logic               i_candidate_3,
  input  logic               i_voting_over,
  output logic [COUNT_W-1:0] o_count1,
  output logic [COUNT_W-1:0] o_count2,
  output logic [COUNT_W-1:0] o_count3
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RELEASE = 2'd1,
    DONE         = 2'd2
  } state_t;

  state_t             r_state;
  logic [COUNT_W-1:0] r_tally1;
  logic [COUNT_W-1:0] r_tally2;
  logic [COUNT_W-1:0] r_tally3;

  logic w_any;
  logic w_multi;

  assign w_any   = i_candidate_1 | i_candidate_2 | i_candidate_3;
  // Two or more buttons at once is an ambiguous vote and is discarded.
  assign w_multi = (i_candidate_1 & i_candidate_2) |
                   (i_candidate_1 & i_candidate_3) |
                   (i_candidate_2 & i_candidate_3);

  // Increment that sticks at the all-ones value instead of wrapping to 0.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    logic [COUNT_W-1:0] r;
    r = (&v) ? v : v + COUNT_W'(1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_tally1 <= '0;
      r_tally2 <= '0;
      r_tally3 <= '0;
      o_count1 <= '0;
      o_count2 <= '0;
      o_count3 <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Closing the poll takes precedence over a press on the same edge.
          if (i_voting_over) begin
            r_state  <= DONE;
            o_count1 <= r_tally1;
            o_count2 <= r_tally2;
            o_count3 <= r_tally3;
          end else if (w_any) begin
            if (!w_multi) begin
              if (i_candidate_1) r_tally1 <= sat_inc(r_tally1);
              if (i_candidate_2) r_tally2 <= sat_inc(r_tally2);
              if (i_candidate_3) r_tally3 <= sat_inc(r_tally3);
            end
            r_state <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          // A held button produces a single vote: nothing counts until all
          // buttons have been released.
          if (i_voting_over) begin
            r_state  <= DONE;
            o_count1 <= r_tally1;
            o_count2 <= r_tally2;
            o_count3 <= r_tally3;
          end else if (!w_any) begin
            r_state <= IDLE;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voting_machine.sv
module tb_voting_machine;

  localparam int COUNT_W = 6;

  logic               clk;
  logic               rst;
  logic               i_candidate_1;
  logic               i_candidate_2;
  logic               i_candidate_3;
  logic               i_voting_over;
  logic [COUNT_W-1:0] o_count1;
  logic [COUNT_W-1:0] o_count2;
  logic [COUNT_W-1:0] o_count3;

  voting_machine #(.COUNT_W(COUNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_candidate_1 (i_candidate_1),
    .i_candidate_2 (i_candidate_2),
    .i_candidate_3 (i_candidate_3),
    .i_voting_over (i_voting_over),
    .o_count1      (o_count1),
    .o_count2      (o_count2),
    .o_count3      (o_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               rst;
    logic               c1;
    logic               c2;
    logic               c3;
    logic               vo;
    logic [COUNT_W-1:0] e1;
    logic [COUNT_W-1:0] e2;
    logic [COUNT_W-1:0] e3;
    string              tag;
  } vec_t;

  typedef struct {
    logic [COUNT_W-1:0] e1;
    logic [COUNT_W-1:0] e2;
    logic [COUNT_W-1:0] e3;
    string              tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  // Monitor: after every rising edge, compare outputs against the oldest
  // pending expectation.
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      total++;
      if (o_count1 !== e.e1 || o_count2 !== e.e2 || o_count3 !== e.e3) begin
        bad++;
        $display("FAIL %s: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 e.tag, o_count1, o_count2, o_count3, e.e1, e.e2, e.e3);
      end
    end
  end

  task automatic add(input logic r, input logic a, input logic b, input logic c,
                     input logic v, input int e1, input int e2, input int e3,
                     input string tag);
    vec_t x;
    x.rst = r; x.c1 = a; x.c2 = b; x.c3 = c; x.vo = v;
    x.e1 = COUNT_W'(e1); x.e2 = COUNT_W'(e2); x.e3 = COUNT_W'(e3);
    x.tag = tag;
    vecs.push_back(x);
  endtask

  // One press cycle followed by two idle cycles; outputs must stay hidden.
  task automatic add_press(input int cand, input string tag);
    add(1'b1, cand == 1, cand == 2, cand == 3, 1'b0, 0, 0, 0, tag);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, tag);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, tag);
  endtask

  // Drive one cycle of stimulus on the falling edge and queue its expectation.
  task automatic drive(input logic r, input logic a, input logic b, input logic c,
                       input logic v, input int e1, input int e2, input int e3,
                       input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; i_candidate_1 = a; i_candidate_2 = b; i_candidate_3 = c;
    i_voting_over = v;
    e.e1 = COUNT_W'(e1); e.e2 = COUNT_W'(e2); e.e3 = COUNT_W'(e3);
    e.tag = tag;
    sbq.push_back(e);
  endtask

  initial begin
    rst = 1'b0;
    i_candidate_1 = 1'b0; i_candidate_2 = 1'b0; i_candidate_3 = 1'b0;
    i_voting_over = 1'b0;

    // Reset held with buttons toggling, then released.
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, "reset_c1");
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, "reset_c23");
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "post_reset");
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "post_reset");

    // Basic poll: c1,c2,c1,c3,c2,c2,c1,c3 -> 3/3/2.
    add_press(1, "poll_c1");
    add_press(2, "poll_c2");
    add_press(1, "poll_c1");
    add_press(3, "poll_c3");
    add_press(2, "poll_c2");
    add_press(2, "poll_c2");
    add_press(1, "poll_c1");
    add_press(3, "poll_c3");
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 3, 2, "poll_result");
    // DONE: results hold, presses ignored, voting_over dropped.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3, 2, "done_hold");
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 3, 2, "done_press1");
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3, 2, "done_gap");
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 3, 2, "done_press2");
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3, 2, "done_gap");
    // Reset from DONE, then a fresh poll is accepted.
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "done_reset");
    add_press(3, "newpoll_c3");
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1, "newpoll_result");

    // Two buttons on one edge are discarded; c3 alone counts.
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "multi_reset");
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, "multi_c13");
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "multi_rel");
    add_press(3, "multi_c3");
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1, "multi_result");

    // Button switched while another still held: no second vote.
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "switch_reset");
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, "switch_c1");
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, "switch_c2");
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "switch_rel");
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, "switch_result");

    // Press on the same edge as voting_over is not counted.
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "race_reset");
    add_press(1, "race_c1");
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, "race_c2_vo");
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0, "race_hold");

    for (int i = 0; i < vecs.size(); i++)
      drive(vecs[i].rst, vecs[i].c1, vecs[i].c2, vecs[i].c3, vecs[i].vo,
            vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].tag);

    // Hold c2 for 10 cycles -> exactly one vote.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "hold_reset");
    for (int i = 0; i < 10; i++)
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, "hold_c2");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "hold_rel");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 0, "hold_result");

    // 70 separate presses of c1 saturate at 63.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "sat_reset");
    for (int i = 0; i < 70; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, "sat_press");
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "sat_gap");
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 63, 0, 0, "sat_result");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 63, 0, 0, "sat_hold");

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
